axis_packet_master: RTL
=======================

Name: axis_packet_master

Overview:
- Parametrised AXI4-Stream master with a FIFO_DEPTH-entry output FIFO and packet framing.
- The internal producer pushes beats with send/full flow control. The block drains the FIFO onto the AXI-Stream bus under tvalid/tready.
- Per packet, it locks tid/tdest and normalises tkeep/tstrb. It reports packet completion and beat/packet counts.
- Sits between the MAC/hash engines and the outbound AXI-Stream interconnect.

Parameters:
- TDATA_WIDTH, 512, data width in bits; multiple of 8.
- TID_WIDTH, 8, tid width.
- TDEST_WIDTH, 8, tdest width.
- TUSER_WIDTH, 8, tuser width.
- FIFO_DEPTH, 4, FIFO entries; power of 2, >= 2.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- data_in  in  TDATA_WIDTH  beat payload.
- keep_in  in  TDATA_WIDTH/8  byte-valid mask; only honoured on last beat.
- last_in  in  1  beat is the final beat of its packet.
- id_in  in  TID_WIDTH  packet id; sampled on the first beat only.
- dest_in  in  TDEST_WIDTH  packet destination; sampled on the first beat only.
- user_in  in  TUSER_WIDTH  per-beat sideband.
- send  in  1  push request.
- full  out  1  FIFO full; push refused.
- level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- done  out  1  one-cycle pulse: a tlast beat was accepted.
- pkt_count  out  16  packets completed, wraps.
- tready  in  1  AXI sink ready.
- tvalid  out  1  head entry valid.
- tdata  out  TDATA_WIDTH  head payload.
- tstrb  out  TDATA_WIDTH/8  equals tkeep.
- tkeep  out  TDATA_WIDTH/8  byte mask.
- tlast  out  1  head is last beat.
- tid  out  TID_WIDTH  head packet id.
- tdest  out  TDEST_WIDTH  head destination.
- tuser  out  TUSER_WIDTH  head sideband.
- stall_cnt  out  16  see Optional Feature.

Behaviour:
- Reset, synchronous and active-high:
  - FIFO empties; level=0, full=0, tvalid=0; tdata/tkeep/tstrb/tid/tdest/tuser/tlast=0.
  - done=0, pkt_count=0, stall_cnt=0; framing FSM to IDLE.
  - Reset mid-packet discards all queued beats; no done pulse.
- Push: accepted when send && !full, where full is the registered value.
  - A send while full is dropped silently; the producer must hold send until !full.
- Pop: occurs when tvalid && tready.
- Simultaneous push and pop:
  - When not full, level unchanged.
  - When full, the push is refused even though a pop occurs. full is registered, so no same-cycle bypass.
- Latency: a beat pushed into an empty FIFO shows tvalid=1 on the next cycle. There is no combinational path from send to tvalid.
- AXI rule: once tvalid=1, the head fields stay stable until accepted. tvalid never drops without a pop.
- Framing FSM, on push side:
  - IDLE: an accepted push latches id_in/dest_in into pkt_id/pkt_dest and stores them with the beat.
    - last_in=0 -> IN_PKT.
    - last_in=1 -> stay IDLE; single-beat packet.
  - IN_PKT: accepted pushes store the latched pkt_id/pkt_dest; id_in/dest_in are ignored.
    - Accepted push with last_in=1 -> IDLE.
- tkeep normalisation:
  - Non-last beats store an all-ones keep.
  - Last beats store keep_in; if keep_in==0, store all-ones.
  - tstrb = tkeep always.
- Pointers: log2(FIFO_DEPTH) bits, wrap modulo FIFO_DEPTH. full = (level==FIFO_DEPTH).
- done: registered; high for exactly one cycle following each cycle with tvalid && tready && tlast.
- pkt_count: increments in the same cycle done is set; wraps 0xFFFF -> 0.

Optional Feature:
- Macro: AXIS_PACKET_MASTER_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle with tvalid && !tready, saturates at 0xFFFF, and clears only on areset.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Single-beat packet: after reset, push data=0xA5..., last_in=1, keep_in=0x000F, id_in=3, with tready=1 -> next cycle tvalid=1, tlast=1, tkeep=tstrb=0x000F, tid=3. done pulses the following cycle; pkt_count=1.
- Fill and backpressure: tready=0, push 5 beats with FIFO_DEPTH=4 -> full=1 after 4 beats, level=4, 5th beat dropped. Raise tready -> exactly 4 beats emerge in push order.
- Header lock: 3-beat packet with id_in=1,7,9 and dest_in=2,5,6 -> all 3 output beats carry tid=1, tdest=2. Non-last tkeep=all-ones; last tkeep=keep_in.
- Throughput: continuous send with tready=1 for 20 beats in 4-beat packets -> one beat per cycle after first, level stays 1, done pulses 5 times, pkt_count=5.
- Reset mid-packet: push 2 beats of a 4-beat packet with tready=0, assert areset one cycle -> tvalid=0, level=0, no done, pkt_count=0. The next push is treated as a first beat and its id is latched.
- Stall counter (macro defined): tvalid=1, tready=0 for 10 cycles -> stall_cnt=10. Macro undefined -> stall_cnt=0.

Source files
------------

// File: rtl/axis_packet_if.sv
// ---------------------------------------------------------------------------
// axis_packet_if
//   AXI4-Stream bus bundle used by axis_packet_master.
//
//   Parameters : TDATA_WIDTH, TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH
//   Signals    : tvalid, tready, tdata, tstrb, tkeep, tlast, tid, tdest, tuser
//   Modports   : master - drives everything except tready
//                slave  - drives tready only
// ---------------------------------------------------------------------------
interface axis_packet_if #(
    parameter int TDATA_WIDTH = 512,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 8
);
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TUSER_WIDTH-1:0]     tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axis_packet_master.sv
// ---------------------------------------------------------------------------
// axis_packet_master
//   AXI4-Stream master with a FIFO_DEPTH-entry output FIFO and packet framing.
//   The local producer pushes beats with send/full flow control; the FIFO
//   drains onto m_axis under tvalid/tready. tid/tdest are locked per packet
//   from the first beat, and tkeep/tstrb are normalised (all-ones on non-last
//   beats, keep_in on the last beat with zero meaning all-ones).
//
//   Ports:
//     aclk, areset      clock, synchronous active-high reset
//     data_in..user_in  beat fields from the producer
//     send / full       push request / FIFO full (registered)
//     level             FIFO occupancy
//     done              one-cycle pulse after a tlast beat is accepted
//     pkt_count         completed packets, wraps at 16 bits
//     stall_cnt         cycles with tvalid && !tready (saturating)
//     m_axis            AXI4-Stream master side (axis_packet_if.master)
//
//   Build option:
//     AXIS_PACKET_MASTER_STALL_CNT_EN - when defined, builds the stall
//     counter; otherwise stall_cnt is tied to zero.
// ---------------------------------------------------------------------------
module axis_packet_master #(
    parameter int TDATA_WIDTH = 512,
    parameter int TID_WIDTH   = 8,
    parameter int TDEST_WIDTH = 8,
    parameter int TUSER_WIDTH = 8,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          aclk,
    input  logic                          areset,

    input  logic [TDATA_WIDTH-1:0]        data_in,
    input  logic [TDATA_WIDTH/8-1:0]      keep_in,
    input  logic                          last_in,
    input  logic [TID_WIDTH-1:0]          id_in,
    input  logic [TDEST_WIDTH-1:0]        dest_in,
    input  logic [TUSER_WIDTH-1:0]        user_in,
    input  logic                          send,
    output logic                          full,
    output logic [$clog2(FIFO_DEPTH):0]   level,

    output logic                          done,
    output logic [15:0]                   pkt_count,
    output logic [15:0]                   stall_cnt,

    axis_packet_if.master                 m_axis
);

    localparam int KEEP_W = TDATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;

    typedef struct packed {
        logic [TDATA_WIDTH-1:0] data;
        logic [KEEP_W-1:0]      keep;
        logic                   last;
        logic [TID_WIDTH-1:0]   id;
        logic [TDEST_WIDTH-1:0] dest;
        logic [TUSER_WIDTH-1:0] user;
    } entry_t;

    typedef enum logic {
        S_IDLE,
        S_IN_PKT
    } state_e;

    entry_t mem [FIFO_DEPTH];

    state_e                 state_q,     state_d;
    logic [TID_WIDTH-1:0]   pkt_id_q,    pkt_id_d;
    logic [TDEST_WIDTH-1:0] pkt_dest_q,  pkt_dest_d;
    logic [PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [LVL_W-1:0]       level_q,     level_d;
    logic                   full_q,      full_d;
    logic                   done_q,      done_d;
    logic [15:0]            pkt_count_q, pkt_count_d;

    logic   push;
    logic   pop;
    logic   head_valid;
    entry_t head;
    entry_t wr_entry;

    assign head       = mem[rd_ptr_q];
    // tvalid comes only from registered occupancy, so send never reaches it
    // combinationally and the head stays put until it is popped.
    assign head_valid = (level_q != '0);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned; otherwise synthesis infers a latch.
        state_d     = state_q;
        pkt_id_d    = pkt_id_q;
        pkt_dest_d  = pkt_dest_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;

        // full_q is the registered flag: a pop in the same cycle does not
        // free a slot for a push until the next cycle.
        push = send && !full_q;
        pop  = head_valid && m_axis.tready;

        // First beat of a packet carries id_in/dest_in; later beats reuse
        // the values latched from that first beat.
        wr_entry.data = data_in;
        wr_entry.user = user_in;
        wr_entry.last = last_in;
        wr_entry.id   = (state_q == S_IDLE) ? id_in   : pkt_id_q;
        wr_entry.dest = (state_q == S_IDLE) ? dest_in : pkt_dest_q;
        if (!last_in || keep_in == '0) begin
            wr_entry.keep = '1;
        end else begin
            wr_entry.keep = keep_in;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (state_q == S_IDLE) begin
                pkt_id_d   = id_in;
                pkt_dest_d = dest_in;
            end
            state_d = last_in ? S_IDLE : S_IN_PKT;
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
        full_d      = (level_d == LVL_W'(FIFO_DEPTH));
        done_d      = pop && head.last;
        pkt_count_d = pkt_count_q + 16'(done_d);
    end

    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (areset) begin
            state_q     <= S_IDLE;
            pkt_id_q    <= '0;
            pkt_dest_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            done_q      <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            pkt_id_q    <= pkt_id_d;
            pkt_dest_q  <= pkt_dest_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            done_q      <= done_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // NOTE: the storage array has no reset; stale contents are never visible
    // because the output fields are forced to zero whenever the FIFO is empty.
    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_entry;
        end
    end

`ifdef AXIS_PACKET_MASTER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (head_valid && !m_axis.tready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

    assign full      = full_q;
    assign level     = level_q;
    assign done      = done_q;
    assign pkt_count = pkt_count_q;

    assign m_axis.tvalid = head_valid;
    assign m_axis.tdata  = head_valid ? head.data : '0;
    assign m_axis.tkeep  = head_valid ? head.keep : '0;
    assign m_axis.tstrb  = head_valid ? head.keep : '0;
    assign m_axis.tlast  = head_valid && head.last;
    assign m_axis.tid    = head_valid ? head.id   : '0;
    assign m_axis.tdest  = head_valid ? head.dest : '0;
    assign m_axis.tuser  = head_valid ? head.user : '0;

endmodule
